// File: rtl/detector_seq_ctrl_if.sv
// Bundle of the attempt-request and detector-handshake signals used by
// detector_seq_ctrl. The master side drives requests and the detector
// response; the slave side is the controller.
interface detector_seq_ctrl_if #(
  parameter int CODE_LEN = 12
);
  logic                start;
  logic [CODE_LEN-1:0] code;
  logic                det_out;
  logic                det_in;
  logic                det_rst;
  logic                busy;
  logic                granted;
  logic                denied;
  logic                locked;
  logic [1:0]          fail_cnt;

  modport master (
    output start, code, det_out,
    input  det_in, det_rst, busy, granted, denied, locked, fail_cnt
  );

  modport slave (
    input  start, code, det_out,
    output det_in, det_rst, busy, granted, denied, locked, fail_cnt
  );
endinterface

// File: rtl/detector_seq_ctrl.sv
// Access-attempt sequencer for an external serial sequence detector.
// An accepted attempt clears the detector, shifts the latched code into it
// MSB first, then waits a short window for the match flag. Consecutive
// denials are counted; reaching MAX_FAIL holds the detector in reset for a
// fixed lockout period. Every output is a flop, loaded with the value that
// belongs to the state being entered.
module detector_seq_ctrl #(
  parameter int CODE_LEN    = 12,
  parameter int RESP_WAIT   = 2,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  detector_seq_ctrl_if.slave  bus
);

  localparam int IDX_W  = $clog2(CODE_LEN + 1);
  localparam int WAIT_W = $clog2(RESP_WAIT + 1);
  localparam int LT_W   = $clog2(LOCK_CYCLES + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESP_WAIT - 1);
  localparam logic [LT_W-1:0]   LOCK_LAST = LT_W'(LOCK_CYCLES - 1);
  localparam logic [1:0]        FAIL_MAX  = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_WAIT,
    S_GRANT,
    S_DENY,
    S_LOCKOUT
  } state_e;

  state_e              state_q,    state_d;
  logic [CODE_LEN-1:0] sreg_q,     sreg_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [WAIT_W-1:0]   wait_q,     wait_d;
  logic [LT_W-1:0]     lock_tmr_q, lock_tmr_d;
  logic [1:0]          fail_cnt_q, fail_cnt_d;
  logic                det_in_q,   det_in_d;
  logic                det_rst_q,  det_rst_d;
  logic                busy_q,     busy_d;
  logic                granted_q,  granted_d;
  logic                denied_q,   denied_d;
  logic                locked_q,   locked_d;

  // Next-state and next-output decode; outputs are chosen for the state being entered.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    sreg_d     = sreg_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    lock_tmr_d = lock_tmr_q;
    fail_cnt_d = fail_cnt_q;
    det_in_d   = 1'b0;
    det_rst_d  = 1'b0;
    busy_d     = 1'b1;
    granted_d  = 1'b0;
    denied_d   = 1'b0;
    locked_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          // The code is captured here so later changes on the bus are ignored.
          state_d   = S_CLEAR;
          sreg_d    = bus.code;
          det_rst_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_CLEAR: begin
        state_d  = S_SHIFT;
        idx_d    = '0;
        det_in_d = sreg_q[CODE_LEN-1];
        sreg_d   = sreg_q << 1;
      end

      // det_out is deliberately not looked at while bits are still going in.
      S_SHIFT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_WAIT;
          idx_d   = '0;
          wait_d  = '0;
        end else begin
          idx_d    = idx_q + 1'b1;
          det_in_d = sreg_q[CODE_LEN-1];
          sreg_d   = sreg_q << 1;
        end
      end

      S_WAIT: begin
        if (bus.det_out) begin
          state_d    = S_GRANT;
          granted_d  = 1'b1;
          fail_cnt_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d  = S_DENY;
          denied_d = 1'b1;
          if (fail_cnt_q != FAIL_MAX) begin
            fail_cnt_d = fail_cnt_q + 2'd1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_GRANT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      S_DENY: begin
        if (fail_cnt_q == FAIL_MAX) begin
          state_d    = S_LOCKOUT;
          lock_tmr_d = '0;
          locked_d   = 1'b1;
          det_rst_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_LOCKOUT: begin
        if (lock_tmr_q == LOCK_LAST) begin
          state_d    = S_IDLE;
          lock_tmr_d = '0;
          fail_cnt_d = '0;
          busy_d     = 1'b0;
        end else begin
          lock_tmr_d = lock_tmr_q + 1'b1;
          locked_d   = 1'b1;
          det_rst_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      // NOTE: the code shift register is cleared too; it is small, and a known
      // value keeps det_in free of stale data after any reset.
      sreg_q     <= '0;
      idx_q      <= '0;
      wait_q     <= '0;
      lock_tmr_q <= '0;
      fail_cnt_q <= '0;
      det_in_q   <= 1'b0;
      det_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      granted_q  <= 1'b0;
      denied_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      lock_tmr_q <= lock_tmr_d;
      fail_cnt_q <= fail_cnt_d;
      det_in_q   <= det_in_d;
      det_rst_q  <= det_rst_d;
      busy_q     <= busy_d;
      granted_q  <= granted_d;
      denied_q   <= denied_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.det_in   = det_in_q;
  assign bus.det_rst  = det_rst_q;
  assign bus.busy     = busy_q;
  assign bus.granted  = granted_q;
  assign bus.denied   = denied_q;
  assign bus.locked   = locked_q;
  assign bus.fail_cnt = fail_cnt_q;

endmodule

// File: doc/detector_seq_ctrl.md
DETECTOR_SEQ_CTRL -- requirements
Module: detector_seq_ctrl

Interface
REQ-001 Parameters SHALL be: CODE_LEN, default 12, code length in bits.
REQ-002 Parameters SHALL include: RESP_WAIT, default 2, number of cycles in the response window after the last bit.
REQ-003 Parameters SHALL include: MAX_FAIL, default 3, consecutive denials that trigger lockout.
REQ-004 Parameters SHALL include: LOCK_CYCLES, default 64, lockout duration in cycles.
REQ-005 Port: clk  input  1  single clock; all logic rising-edge.
REQ-006 Port: rst  input  1  synchronous, active-high reset.
REQ-007 Port: start  input  1  attempt request; accepted only in IDLE.
REQ-008 Port: code  input  CODE_LEN  candidate sequence; latched on accept.
REQ-009 Port: det_out  input  1  match flag from the sequence detector.
REQ-010 Port: det_in  output  1  serial bit to the detector.
REQ-011 Port: det_rst  output  1  synchronous reset pulse to the detector.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: granted  output  1  one-cycle pulse on match.
REQ-014 Port: denied  output  1  one-cycle pulse on no-match.
REQ-015 Port: locked  output  1  high throughout LOCKOUT.
REQ-016 Port: fail_cnt  output  2  consecutive-denial count.

Function
REQ-017 The block SHALL implement these states: IDLE, CLEAR, SHIFT, WAIT, GRANT, DENY and LOCKOUT.
REQ-018 All outputs SHALL be registered, changing only on the clk edge.
REQ-019 In IDLE with start=1, the block SHALL latch code and enter CLEAR on the next edge; start in any other state SHALL be ignored.
REQ-020 CLEAR SHALL last 1 cycle with det_rst=1 and det_in=0, then enter SHIFT.
REQ-021 SHIFT SHALL last CODE_LEN cycles, driving det_in MSB first (code[CODE_LEN-1] in the first cycle), with det_rst=0; det_out SHALL be ignored during SHIFT.
REQ-022 WAIT SHALL last up to RESP_WAIT cycles with det_in=0.
- If det_out=1 is sampled in any WAIT cycle, the block SHALL go to GRANT at the next edge.
- If no det_out=1 is sampled by the end of the window, the block SHALL go to DENY.
REQ-023 GRANT SHALL last 1 cycle: granted=1, fail_cnt cleared to 0, then IDLE.
REQ-024 DENY SHALL last 1 cycle: denied=1 and fail_cnt incremented; if the new value equals MAX_FAIL the next state SHALL be LOCKOUT, else IDLE.
REQ-025 LOCKOUT SHALL last exactly LOCK_CYCLES cycles with locked=1 and det_rst=1, then fail_cnt SHALL clear to 0 and the block SHALL enter IDLE.
REQ-026 fail_cnt SHALL saturate and never exceed MAX_FAIL.
REQ-027 The lockout timer SHALL count from 0 to LOCK_CYCLES-1, with no wrap beyond that.
REQ-028 A start held high across completion SHALL be accepted once per return to IDLE, never in the same cycle as GRANT, DENY or LOCKOUT.
REQ-029 A change on code while busy SHALL NOT affect the attempt in progress.

Reset
REQ-030 With rst=1 at an edge, the block SHALL enter IDLE from any state, including mid-SHIFT or mid-LOCKOUT.
REQ-031 Reset values: det_in=0, det_rst=0, busy=0, granted=0, denied=0, locked=0, fail_cnt=0, shift index=0, lockout timer=0.
REQ-032 rst SHALL take priority over start on the same edge.

Verification
REQ-033 Match: start with code=12'b000010010100 accepted at edge 0, model asserts det_out in the first WAIT cycle (cycle 14) -> det_rst=1 in cycle 1, det_in sequence 0,0,0,0,1,0,0,1,0,1,0,0 in cycles 2-13, granted=1 in cycle 15, fail_cnt=0.
REQ-034 Mismatch: code=12'b011000000000 with det_out held 0 -> denied=1 in cycle 16, fail_cnt=1, busy=0 in cycle 17.
REQ-035 Lockout: three consecutive mismatches -> third denied pulse, then locked=1 and det_rst=1 for 64 cycles; start pulses during lockout are ignored; fail_cnt=0 after exit.
REQ-036 Recovery: two mismatches, then a match -> fail_cnt goes 1, 2, then 0, and locked is never asserted.
REQ-037 Mid-operation reset: rst=1 in SHIFT cycle 6, and separately in LOCKOUT cycle 10 -> all outputs reach reset values next cycle, and a new start is accepted immediately.
REQ-038 Spurious det_out=1 during SHIFT with det_out=0 in WAIT -> denied, not granted.
